decomp_ctrl: RTL and testbench

- Control FSM that sequences the decompressor datapath: address counter, the three 16-bit word registers, and the 24-bit output mux.
- Per frame it emits two header words (width 320, height 240) through the mux.
- It then repeatedly loads three 16-bit memory words and emits two 24-bit pixels, until the address counter reports done.
- Output pixels go to a downstream writer over a valid/ready handshake.

---
 rtl/decomp_ctrl.sv | 139 +++++++++++++
 tb/tb_decomp_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decomp_ctrl.sv
// Control FSM for the frame decompressor: emits two header words, then loops
// loading three 16-bit words and emitting two 24-bit pixels until the address counter is done.
module decomp_ctrl #(
  parameter int RD_WAIT   = 1,
  parameter int PIX_CNT_W = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cnt_done,
  output logic                 count_en,
  output logic                 clear,
  output logic                 len0,
  output logic                 len1,
  output logic                 len2,
  output logic [1:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic [PIX_CNT_W-1:0] pix_count
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] CLR   = 4'd1;
  localparam logic [3:0] HDR_W = 4'd2;
  localparam logic [3:0] HDR_H = 4'd3;
  localparam logic [3:0] WAIT0 = 4'd4;
  localparam logic [3:0] LD0   = 4'd5;
  localparam logic [3:0] WAIT1 = 4'd6;
  localparam logic [3:0] LD1   = 4'd7;
  localparam logic [3:0] WAIT2 = 4'd8;
  localparam logic [3:0] LD2   = 4'd9;
  localparam logic [3:0] PIX_A = 4'd10;
  localparam logic [3:0] PIX_B = 4'd11;
  localparam logic [3:0] DONE  = 4'd12;

  // With no read latency the wait states are skipped entirely.
  localparam logic [3:0] ENTER_W0 = (RD_WAIT == 0) ? LD0 : WAIT0;
  localparam logic [3:0] ENTER_W1 = (RD_WAIT == 0) ? LD1 : WAIT1;
  localparam logic [3:0] ENTER_W2 = (RD_WAIT == 0) ? LD2 : WAIT2;
  localparam logic [1:0] WAIT_LOAD = (RD_WAIT > 0) ? 2'(RD_WAIT - 1) : 2'd0;
  localparam logic [PIX_CNT_W-1:0] PIX_ONE = {{(PIX_CNT_W-1){1'b0}}, 1'b1};

  logic [3:0] state;
  logic [3:0] next_state;
  logic [1:0] wait_cnt;
  logic       entering_wait;

  // Handshake: a word transfers on any cycle with out_valid & out_ready; while
  // out_valid is high and out_ready low, state and sel hold and no loads occur.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = CLR;
      CLR:   next_state = HDR_W;
      HDR_W: if (out_ready) next_state = HDR_H;
      HDR_H: if (out_ready) next_state = cnt_done ? DONE : ENTER_W0;
      WAIT0: if (wait_cnt == 2'd0) next_state = LD0;
      LD0:   next_state = ENTER_W1;
      WAIT1: if (wait_cnt == 2'd0) next_state = LD1;
      LD1:   next_state = ENTER_W2;
      WAIT2: if (wait_cnt == 2'd0) next_state = LD2;
      LD2:   next_state = PIX_A;
      PIX_A: if (out_ready) next_state = PIX_B;
      PIX_B: if (out_ready) next_state = cnt_done ? DONE : ENTER_W0;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign entering_wait = (next_state != state) &&
                         ((next_state == WAIT0) || (next_state == WAIT1) ||
                          (next_state == WAIT2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 2'd0;
      pix_count <= '0;
    end else begin
      state <= next_state;
      if (entering_wait) begin
        wait_cnt <= WAIT_LOAD;
      end else if (wait_cnt != 2'd0) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
      if (state == CLR) begin
        pix_count <= '0;
      end else if (((state == PIX_A) || (state == PIX_B)) && out_ready) begin
        pix_count <= pix_count + PIX_ONE;
      end
    end
  end

  always_comb begin
    count_en   = 1'b0;
    clear      = 1'b0;
    len0       = 1'b0;
    len1       = 1'b0;
    len2       = 1'b0;
    sel        = 2'd0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE:  busy = 1'b0;
      CLR:   clear = 1'b1;
      HDR_W: out_valid = 1'b1;
      HDR_H: begin
        sel       = 2'd1;
        out_valid = 1'b1;
      end
      LD0: begin
        len0     = 1'b1;
        count_en = 1'b1;
      end
      LD1: begin
        len1     = 1'b1;
        count_en = 1'b1;
      end
      LD2: begin
        len2     = 1'b1;
        count_en = 1'b1;
      end
      PIX_A: begin
        sel       = 2'd2;
        out_valid = 1'b1;
      end
      PIX_B: begin
        sel       = 2'd3;
        out_valid = 1'b1;
      end
      DONE:  frame_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decomp_ctrl.sv
// Bench for decomp_ctrl: two instances (RD_WAIT=1 and RD_WAIT=0) driving a modelled
// memory/word-register datapath; emitted words are scoreboarded against frame contents.
module tb_decomp_ctrl;
  localparam int PW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          out_ready;
  logic          start_s      [2];
  logic          cnt_done_s   [2];
  logic          count_en_s   [2];
  logic          clear_s      [2];
  logic          len0_s       [2];
  logic          len1_s       [2];
  logic          len2_s       [2];
  logic [1:0]    sel_s        [2];
  logic          out_valid_s  [2];
  logic          busy_s       [2];
  logic          frame_done_s [2];
  logic [PW-1:0] pix_count_s  [2];

  decomp_ctrl #(.RD_WAIT(1), .PIX_CNT_W(PW)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .cnt_done(cnt_done_s[0]),
    .count_en(count_en_s[0]), .clear(clear_s[0]), .len0(len0_s[0]), .len1(len1_s[0]),
    .len2(len2_s[0]), .sel(sel_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready),
    .busy(busy_s[0]), .frame_done(frame_done_s[0]), .pix_count(pix_count_s[0])
  );

  decomp_ctrl #(.RD_WAIT(0), .PIX_CNT_W(PW)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .cnt_done(cnt_done_s[1]),
    .count_en(count_en_s[1]), .clear(clear_s[1]), .len0(len0_s[1]), .len1(len1_s[1]),
    .len2(len2_s[1]), .sel(sel_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready),
    .busy(busy_s[1]), .frame_done(frame_done_s[1]), .pix_count(pix_count_s[1])
  );

  // ---------------- datapath model: memory with read latency, counter, word regs
  logic [15:0] mem [32];
  int          limit;
  logic [7:0]  addr [2];
  int          age  [2];
  logic [15:0] r0 [2];
  logic [15:0] r1 [2];
  logic [15:0] r2 [2];

  function automatic logic [15:0] rdata(input int i);
    int w;
    w = (i == 0) ? 1 : 0;
    if (age[i] >= w) return mem[addr[i][4:0]];
    return 16'hDEAD;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (len0_s[i]) r0[i] <= rdata(i);
      if (len1_s[i]) r1[i] <= rdata(i);
      if (len2_s[i]) r2[i] <= rdata(i);
      if (rst || clear_s[i]) begin
        addr[i] <= 8'd0;
        age[i]  <= 0;
      end else if (count_en_s[i]) begin
        addr[i] <= addr[i] + 8'd1;
        age[i]  <= 0;
      end else if (age[i] < 8) begin
        age[i] <= age[i] + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) cnt_done_s[i] = (int'(addr[i]) >= limit);
  end

  function automatic logic [23:0] mux_word(input int i);
    case (sel_s[i])
      2'd0:    return 24'd320;
      2'd1:    return 24'd240;
      2'd2:    return {r1[i][7:0], r0[i]};
      default: return {r2[i], r1[i][15:8]};
    endcase
  endfunction

  // ---------------- scoreboard
  logic [23:0]   exp_q [$];
  logic [PW-1:0] pc_q  [$];
  int   errors = 0;
  int   checks = 0;
  int   act = 0;
  int   viol = 0;
  logic pend = 1'b0;
  logic [1:0] pend_sel = 2'd0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("hold_valid", 32'(out_valid_s[act]), 32'd1);
        chk("hold_sel", 32'(sel_s[act]), 32'(pend_sel));
      end
      if (out_valid_s[act] &&
          (count_en_s[act] || len0_s[act] || len1_s[act] || len2_s[act])) viol++;
      if (out_valid_s[act] && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_word: got %0h expected none", mux_word(act));
        end else begin
          chk("out_word", 32'(mux_word(act)), 32'(exp_q.pop_front()));
        end
      end
      if (frame_done_s[act]) begin
        if (pc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_done: got pulse expected none");
        end else begin
          chk("pix_count_done", 32'(pix_count_s[act]), 32'(pc_q.pop_front()));
        end
      end
      pend     = out_valid_s[act] && !out_ready;
      pend_sel = sel_s[act];
    end
  end

  // ---------------- stimulus
  task automatic load_frame(input int d, input int lim, output int g);
    act   = d;
    limit = lim;
    g     = (lim + 2) / 3;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    exp_q.push_back(24'd320);
    exp_q.push_back(24'd240);
    for (int k = 0; k < g; k++) begin
      exp_q.push_back({mem[3*k+1][7:0], mem[3*k]});
      exp_q.push_back({mem[3*k+2], mem[3*k+1][15:8]});
    end
    pc_q.push_back(PW'(2 * g));
  endtask

  task automatic run_frame(input int d, input int lim, input int rdy_pct,
                           input bit poke, input bit bp);
    int g, w, done_at, n0, n1, n2, nce, nclr, f0, f1, f2, bp_left;
    bit bp_done;
    logic [PW-1:0] bp_pc;
    w = (d == 0) ? 1 : 0;
    load_frame(d, lim, g);
    viol = 0;
    done_at = -1; n0 = 0; n1 = 0; n2 = 0; nce = 0; nclr = 0;
    f0 = -1; f1 = -1; f2 = -1; bp_left = 0; bp_done = 1'b0; bp_pc = '0;
    @(posedge clk); #1;
    start_s[d] = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (clear_s[d]) nclr++;
      if (count_en_s[d]) nce++;
      if (len0_s[d]) begin n0++; if (f0 < 0) f0 = cyc; end
      if (len1_s[d]) begin n1++; if (f1 < 0) f1 = cyc; end
      if (len2_s[d]) begin n2++; if (f2 < 0) f2 = cyc; end
      if (cyc == 1) chk("pix_count_cleared", 32'(pix_count_s[d]), 32'd0);
      if (frame_done_s[d]) begin
        done_at = cyc;
        break;
      end
      if (bp && !bp_done && out_valid_s[d] && sel_s[d] == 2'd2) begin
        bp_left = 5;
        bp_done = 1'b1;
        bp_pc   = pix_count_s[d];
      end
      if (bp_left > 0) begin
        chk("bp_sel", 32'(sel_s[d]), 32'd2);
        chk("bp_pix_count", 32'(pix_count_s[d]), 32'(bp_pc));
        out_ready = 1'b0;
        bp_left--;
      end else begin
        out_ready = ($urandom_range(0, 99) < rdy_pct);
      end
      start_s[d] = poke && (cyc == 4 || cyc == 7);
      @(posedge clk); #1;
    end
    start_s[d] = 1'b0;
    if (done_at < 0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no frame_done expected one within budget");
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      pc_q.delete();
    end else begin
      chk("len0_pulses", 32'(n0), 32'(g));
      chk("len1_pulses", 32'(n1), 32'(g));
      chk("len2_pulses", 32'(n2), 32'(g));
      chk("count_en_pulses", 32'(nce), 32'(3 * g));
      chk("clear_pulses", 32'(nclr), 32'd1);
      if (rdy_pct == 100 && !bp) begin
        chk("frame_cycles", 32'(done_at), 32'(3 + g * (3 * w + 5)));
        if (g > 0) begin
          chk("first_ld0", 32'(f0), 32'(3 + w));
          chk("first_ld1", 32'(f1), 32'(4 + 2 * w));
          chk("first_ld2", 32'(f2), 32'(5 + 3 * w));
        end
      end
      chk("load_under_valid", 32'(viol), 32'd0);
      @(posedge clk); #1;
      chk("frame_done_one_cycle", 32'(frame_done_s[d]), 32'd0);
      chk("idle_busy", 32'(busy_s[d]), 32'd0);
      chk("pix_count_hold", 32'(pix_count_s[d]), 32'(2 * g));
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic check_idle_outputs(input int i, input string tag);
    chk({tag, "_count_en"}, 32'(count_en_s[i]), 32'd0);
    chk({tag, "_clear"}, 32'(clear_s[i]), 32'd0);
    chk({tag, "_lens"}, 32'({len0_s[i], len1_s[i], len2_s[i]}), 32'd0);
    chk({tag, "_sel"}, 32'(sel_s[i]), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid_s[i]), 32'd0);
    chk({tag, "_busy"}, 32'(busy_s[i]), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done_s[i]), 32'd0);
    chk({tag, "_pix_count"}, 32'(pix_count_s[i]), 32'd0);
  endtask

  task automatic reset_mid_frame();
    int g;
    bit seen;
    load_frame(0, 9, g);
    seen = 1'b0;
    @(posedge clk); #1;
    start_s[0] = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (len1_s[0]) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reach_ld1", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rst        = 1'b1;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    start_s[0] = 1'b0;
    exp_q.delete();
    pc_q.delete();
    check_idle_outputs(0, "mid_reset");
    @(posedge clk); #1;
    chk("start_with_rst_ignored", 32'(busy_s[0]), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    limit = 0;
    for (int i = 0; i < 2; i++) start_s[i] = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs(0, "reset0");
    check_idle_outputs(1, "reset1");
    rst = 1'b0;

    run_frame(0, 3, 100, 1'b0, 1'b0);
    run_frame(0, 7, 100, 1'b0, 1'b1);
    run_frame(0, 8, 100, 1'b1, 1'b0);
    run_frame(0, 0, 100, 1'b0, 1'b0);
    run_frame(1, 6, 100, 1'b0, 1'b0);
    run_frame(1, 0, 100, 1'b0, 1'b0);
    reset_mid_frame();
    run_frame(0, 9, 100, 1'b0, 1'b0);
    for (int n = 0; n < 12; n++) begin
      run_frame($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(40, 100),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
